// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 keypad scanner.
//                Provides the scanner state type, the row/column key map and
//                small helpers that inspect a synchronised active-low row
//                vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // KEYMAP[row][col]. The packed concatenation lists the highest index first,
    // so each row literal reads column 3 down to column 0.
    localparam logic [NUM_ROWS-1:0][NUM_COLS-1:0][3:0] KEYMAP = {
        {4'hD, 4'hF, 4'h0, 4'hE},   // row 3: E 0 F D
        {4'hC, 4'h9, 4'h8, 4'h7},   // row 2: 7 8 9 C
        {4'hB, 4'h6, 4'h5, 4'h4},   // row 1: 4 5 6 B
        {4'hA, 4'h3, 4'h2, 4'h1}    // row 0: 1 2 3 A
    };

    // Index of the lowest-numbered row pulled low (0 when none is low).
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // True when more than one row is pulled low.
    function automatic logic multi_low(input logic [NUM_ROWS-1:0] rows);
        return ($countones(~rows) > 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_row_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : row_synchronizer
//  Description : Two-flop synchroniser for the asynchronous active-low keypad
//                rows. Reset parks both stages at "no row low".
//  Ports       : clk   - system clock
//                reset - synchronous, active-high reset
//                row_n - raw keypad rows (asynchronous)
//                row_s - synchronised rows
//  Revision    : 1.0 - initial release
// ============================================================================
module row_synchronizer
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_ROWS-1:0] row_s
);

    logic [NUM_ROWS-1:0] r_meta;
    logic [NUM_ROWS-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= row_n;
            r_sync <= r_meta;
        end
    end

    assign row_s = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner with press/release debouncing,
//                one event per press and a two-digit key history.
//  Ports       : clk       - system clock
//                reset     - synchronous, active-high reset
//                row_n     - keypad rows, active-low, asynchronous
//                col_n     - column drive, active-low, one-cold
//                key_valid - one-cycle pulse per accepted press
//                key_code  - code of the last accepted key
//                key_held  - accepted key still down or release debouncing
//                digit_new - most recent accepted key
//                digit_old - key accepted before digit_new
//  Config      : KEYPAD_MULTIKEY_REJECT_EN - when defined, a scan sample with
//                several rows low is ignored and an extra row going low
//                during press debounce aborts the press.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic                key_held,
    output logic [3:0]          digit_new,
    output logic [3:0]          digit_old
);

    localparam int CNT_MAX = (SCAN_TICKS > DEBOUNCE_CYCLES) ? SCAN_TICKS : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] C_SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] C_DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ROWS-1:0] w_row_s;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_col;
    logic [1:0]          w_col_nxt;
    logic [1:0]          r_row;
    logic [1:0]          w_row_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_accept;
    logic                w_scan_take;
    logic                w_abort_extra;
    logic                r_key_valid;
    logic [3:0]          r_key_code;
    logic [3:0]          r_digit_new;
    logic [3:0]          r_digit_old;

    row_synchronizer u_row_sync (
        .clk   (clk),
        .reset (reset),
        .row_n (row_n),
        .row_s (w_row_s)
    );

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    logic w_others_low;
    // Any row other than the latched one pulled low.
    assign w_others_low  = |(~w_row_s & ~(4'b0001 << r_row));
    assign w_scan_take   = (w_row_s != 4'hF) && !multi_low(w_row_s);
    assign w_abort_extra = w_others_low;
`else
    assign w_scan_take   = (w_row_s != 4'hF);
    assign w_abort_extra = 1'b0;
`endif

    // Next-state logic. Column only advances when leaving for the next scan
    // slot; during debounce/held/release the pressed column stays driven so
    // the latched row keeps reflecting the same key.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_accept    = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_cnt == C_SCAN_LAST) begin
                    if (w_scan_take) begin
                        w_row_nxt   = lowest_low(w_row_s);
                        w_state_nxt = DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (w_row_s[r_row] || w_abort_extra) begin
                    w_state_nxt = SCAN;
                    w_col_nxt   = r_col + 2'd1;
                end else if (r_cnt == C_DEB_LAST) begin
                    w_state_nxt = HELD;
                    w_accept    = 1'b1;
                end
            end
            HELD: begin
                if (w_row_s[r_row]) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_row_s[r_row]) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == C_DEB_LAST) begin
                    w_state_nxt = SCAN;
                    w_col_nxt   = r_col + 2'd1;
                end
            end
            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SCAN;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            // The counter times each state/column dwell from zero.
            if ((w_state_nxt != r_state) || (w_col_nxt != r_col)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_digit_new <= 4'h0;
            r_digit_old <= 4'h0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code  <= KEYMAP[r_row][r_col];
                r_digit_new <= KEYMAP[r_row][r_col];
                r_digit_old <= r_digit_new;
            end
        end
    end

    assign col_n     = ~(4'b0001 << r_col);
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = (r_state == HELD) || (r_state == RELEASE);
    assign digit_new = r_digit_new;
    assign digit_old = r_digit_old;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner with a simulated 4x4
//                key matrix (SCAN_TICKS=4, DEBOUNCE_CYCLES=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    logic [15:0] keys;          // bit r*4+c set = key at row r / column c is down
    logic [3:0]  km [4][4];     // key map as read off the keypad legend
    int          n_checks;
    int          n_fail;
    int          pulses;
    logic        prev_valid;
    logic [3:0]  exp_new;
    logic [3:0]  exp_old;
    logic [3:0]  exp_code;

    keypad_scanner #(
        .SCAN_TICKS      (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: a pressed key connects its column to its row.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (col_n[c] == 1'b0)) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Event monitor: counts pulses and checks each lasts exactly one cycle.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulses++;
            check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        end
        prev_valid = key_valid;
    end

    function automatic void model_event(input logic [3:0] code);
        exp_old  = exp_new;
        exp_new  = code;
        exp_code = code;
    endfunction

    // Press one key for 'hold' cycles, release, let the release settle.
    task automatic do_press(input int r, input int c, input int hold, input int exp_p,
                            input logic [3:0] exp_c, input string name);
        int p0;
        p0 = pulses;
        keys[r*4+c] = 1'b1;
        tick(hold);
        if (exp_p == 1) begin
            model_event(exp_c);
            check({name, "_held"}, {31'd0, key_held}, 32'd1);
        end
        keys = '0;
        check({name, "_pulses"}, pulses - p0, exp_p);
        check({name, "_code"}, {28'd0, key_code}, {28'd0, exp_code});
        check({name, "_new"}, {28'd0, digit_new}, {28'd0, exp_new});
        check({name, "_old"}, {28'd0, digit_old}, {28'd0, exp_old});
        tick(40);
        check({name, "_released"}, {31'd0, key_held}, 32'd0);
    endtask

    typedef struct {
        int         r;
        int         c;
        int         hold;
        int         exp_p;
        logic [3:0] exp_c;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        logic [3:0] exp_col;
        logic [3:0] prev_col;
        int         p0;
        int         t;

        km = '{'{4'h1, 4'h2, 4'h3, 4'hA},
               '{4'h4, 4'h5, 4'h6, 4'hB},
               '{4'h7, 4'h8, 4'h9, 4'hC},
               '{4'hE, 4'h0, 4'hF, 4'hD}};
        vecs = '{'{0, 3, 100, 1, 4'hA},
                 '{3, 0, 100, 1, 4'hE},
                 '{3, 3, 100, 1, 4'hD},
                 '{2, 1, 100, 1, 4'h8},
                 '{1, 0,   8, 0, 4'h8},
                 '{0, 1, 100, 1, 4'h2}};
        n_checks = 0; n_fail = 0; pulses = 0; prev_valid = 1'b0;
        exp_new = 4'h0; exp_old = 4'h0; exp_code = 4'h0;
        keys  = '0;
        reset = 1'b1;

        // 1. reset values and free-running column scan
        tick(2);
        check("rst_col", {28'd0, col_n}, 32'hE);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check("rst_digits", {24'd0, digit_new, digit_old}, 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("scan_col", {28'd0, col_n}, {28'd0, exp_col});
        end
        check("scan_no_pulse", pulses, 0);
        check("scan_digits", {24'd0, digit_new, digit_old}, 32'd0);

        // 2. clean press of '6'
        p0 = pulses;
        keys[1*4+2] = 1'b1;
        tick(200);
        check("k6_pulses", pulses - p0, 1);
        check("k6_code", {28'd0, key_code}, 32'h6);
        check("k6_new", {28'd0, digit_new}, 32'h6);
        check("k6_old", {28'd0, digit_old}, 32'h0);
        check("k6_held", {31'd0, key_held}, 32'd1);
        model_event(4'h6);
        keys = '0;
        tick(8);
        check("k6_release_debouncing", {31'd0, key_held}, 32'd1);
        tick(40);
        check("k6_released", {31'd0, key_held}, 32'd0);

        // 3. bouncing '6' never settles -> no event, scan resumes
        p0 = pulses;
        for (int i = 0; i < 7; i++) begin
            keys[1*4+2] = 1'b1; tick(3);
            keys = '0;          tick(3);
        end
        tick(30);
        check("bounce_no_pulse", pulses - p0, 0);
        check("bounce_held", {31'd0, key_held}, 32'd0);
        prev_col = col_n;
        tick(4);
        check("bounce_scan_moves", {31'd0, (col_n != prev_col)}, 32'd1);

        // 4. '6' with bouncy release, then '0'
        p0 = pulses;
        keys[1*4+2] = 1'b1; tick(200);
        model_event(4'h6);
        check("b6_code", {28'd0, key_code}, 32'h6);
        keys = '0; tick(5); keys[1*4+2] = 1'b1; tick(3);
        keys = '0; tick(4); keys[1*4+2] = 1'b1; tick(2);
        keys = '0; tick(3); keys[1*4+2] = 1'b1; tick(2);
        check("b6_held_in_bounce", {31'd0, key_held}, 32'd1);
        keys = '0; tick(40);
        check("b6_one_pulse", pulses - p0, 1);
        do_press(3, 1, 200, 1, 4'h0, "k0");
        check("k0_total_pulses", pulses - p0, 2);

        // 5. '1' and '7' together in column 0
        p0 = pulses;
        keys[0*4+0] = 1'b1; keys[2*4+0] = 1'b1;
        tick(200);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        check("multi_pulses", pulses - p0, 0);
`else
        model_event(4'h1);
        check("multi_pulses", pulses - p0, 1);
`endif
        check("multi_code", {28'd0, key_code}, {28'd0, exp_code});
        check("multi_new", {28'd0, digit_new}, {28'd0, exp_new});
        keys = '0; tick(40);

        // 6. reset while a key is held
        keys[1*4+1] = 1'b1;
        t = 0;
        while (key_held !== 1'b1 && t < 100) begin
            tick(1);
            t++;
        end
        check("rh_reached_held", {31'd0, key_held}, 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        keys  = '0;
        exp_new = 4'h0; exp_old = 4'h0; exp_code = 4'h0;
        check("rh_col", {28'd0, col_n}, 32'hE);
        check("rh_held", {31'd0, key_held}, 32'd0);
        check("rh_digits", {24'd0, digit_new, digit_old}, 32'd0);
        check("rh_code", {28'd0, key_code}, 32'd0);
        tick(40);
        do_press(2, 2, 100, 1, 4'h9, "rh_k9");

        // Directed key table
        foreach (vecs[i]) begin
            do_press(vecs[i].r, vecs[i].c, vecs[i].hold, vecs[i].exp_p, vecs[i].exp_c, "tbl");
        end

        // Random taps and presses against the event-level model
        for (int i = 0; i < 16; i++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                do_press(r, c, int'($urandom_range(2, 10)), 0, exp_code, "rnd_tap");
            end else begin
                do_press(r, c, int'($urandom_range(60, 120)), 1, km[r][c], "rnd_press");
            end
            tick(int'($urandom_range(0, 20)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
